// File: rtl/uv_lane_gearbox.sv
// uv_lane_gearbox
//   Read gearbox between the wide u/v-minus-uy result RAM (RAMWIDTH bits per
//   word) and the RM/RS decoder (DEC_WIDTH bits per word). A logical decoder
//   word address is split into a physical RAM word address and a lane index.
//   The lane index travels through a pipe whose depth matches the RAM read
//   latency. The selected lane is masked beyond bit N of the vector and
//   returned at a fixed latency of RD_LAT+1 cycles after acceptance.
//
//   Optional feature: define UV_GEARBOX_CACHE_EN to add a one-entry
//   tag/valid/data cache. Repeat reads of the same physical word are then
//   served without a RAM access. The default build has no cache.
//
// Ports
//   clk        in   1          clock
//   rst        in   1          asynchronous reset, active-high
//   clear      in   1          synchronous flush of in-flight responses and cache
//   req_valid  in   1          decoder read request
//   req_addr   in   LA         logical DEC_WIDTH word index
//   req_ready  out  1          request accepted when req_valid & req_ready
//   ram_rd     out  1          physical RAM read enable (combinational)
//   ram_addr   out  PA         physical word index (combinational)
//   ram_dout   in   RAMWIDTH   RAM data, valid RD_LAT cycles after ram_rd
//   rsp_valid  out  1          response strobe (registered)
//   rsp_data   out  DEC_WIDTH  selected, masked lane (registered)

module uv_lane_gearbox #(
    parameter int unsigned RAMWIDTH  = 256,
    parameter int unsigned DEC_WIDTH = 128,
    parameter int unsigned N         = 17669,
    parameter int unsigned RD_LAT    = 1,
    localparam int unsigned RATIO    = RAMWIDTH / DEC_WIDTH,
    localparam int unsigned LDEPTH   = (N + DEC_WIDTH - 1) / DEC_WIDTH,
    localparam int unsigned PDEPTH   = (LDEPTH + RATIO - 1) / RATIO,
    localparam int unsigned LA       = $clog2(LDEPTH),
    localparam int unsigned PA       = ($clog2(PDEPTH) < 1) ? 1 : $clog2(PDEPTH),
    localparam int unsigned LR       = $clog2(RATIO)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 req_valid,
    input  logic [LA-1:0]        req_addr,
    output logic                 req_ready,
    output logic                 ram_rd,
    output logic [PA-1:0]        ram_addr,
    input  logic [RAMWIDTH-1:0]  ram_dout,
    output logic                 rsp_valid,
    output logic [DEC_WIDTH-1:0] rsp_data
);

    // Lane vectors keep at least one bit so RATIO=1 still elaborates.
    localparam int unsigned LW        = (LR > 0) ? LR : 1;
    localparam int unsigned LAST_BITS = N - (LDEPTH - 1) * DEC_WIDTH;
    localparam logic [DEC_WIDTH-1:0] LAST_MASK =
        {DEC_WIDTH{1'b1}} >> (DEC_WIDTH - LAST_BITS);

    logic                accept;
    logic                req_oor;
    logic                req_last;
    logic                hit;
    logic                tail_valid;
    logic                tail_last;
    logic                tail_oor;
    logic [LW-1:0]       tail_lane;
    logic [RAMWIDTH-1:0] tail_word;

    // Request side: accept whenever not in reset or flush.
    assign req_ready = ~rst & ~clear;
    assign accept    = req_valid & req_ready;

    // Compare one bit wider so an LDEPTH equal to 2**LA does not wrap to 0.
    assign req_oor  = ({1'b0, req_addr} >= (LA + 1)'(LDEPTH));
    assign req_last = ({1'b0, req_addr} == (LA + 1)'(LDEPTH - 1));

    assign ram_addr = PA'(req_addr >> LR);
    assign ram_rd   = accept & ~req_oor & ~hit;

    // Latency-matched control pipe; the tail lines up with ram_dout.
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_last;
    logic [RD_LAT-1:0] pipe_oor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
            pipe_oor   <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                pipe_oor[i]   <= pipe_oor[i-1];
            end
            pipe_valid[0] <= accept;
            pipe_last[0]  <= req_last;
            pipe_oor[0]   <= req_oor;
            if (clear) begin
                pipe_valid <= '0;
            end
        end
    end

    assign tail_valid = pipe_valid[RD_LAT-1];
    assign tail_last  = pipe_last[RD_LAT-1];
    assign tail_oor   = pipe_oor[RD_LAT-1];

    // Lane index pipe, only present when a RAM word holds several lanes.
    if (LR > 0) begin : g_lane
        logic [LW-1:0] pipe_lane [RD_LAT];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < RD_LAT; i++) begin
                    pipe_lane[i] <= '0;
                end
            end else begin
                for (int i = RD_LAT - 1; i > 0; i--) begin
                    pipe_lane[i] <= pipe_lane[i-1];
                end
                pipe_lane[0] <= req_addr[LR-1:0];
            end
        end

        assign tail_lane = pipe_lane[RD_LAT-1];
    end else begin : g_no_lane
        assign tail_lane = '0;
    end

`ifdef UV_GEARBOX_CACHE_EN
    // One-entry cache: tag follows the most recent miss issue, data follows
    // that miss's return. In-order delivery means a hit reaching the tail
    // always finds the fill of its tag already in data_reg.
    logic                tag_valid;
    logic [PA-1:0]       tag;
    logic [RAMWIDTH-1:0] data_reg;
    logic [RD_LAT-1:0]   pipe_src;
    logic                tail_src;

    assign hit = tag_valid & (tag == ram_addr) & ~req_oor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_src <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_src[i] <= pipe_src[i-1];
            end
            pipe_src[0] <= hit;
        end
    end

    assign tail_src = pipe_src[RD_LAT-1];

    // Tag and valid bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= 1'b0;
            tag       <= '0;
        end else if (clear) begin
            tag_valid <= 1'b0;
        end else if (ram_rd) begin
            tag_valid <= 1'b1;
            tag       <= ram_addr;
        end
    end

    // Capture the RAM word when a miss reaches the tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else if (tail_valid && !tail_src && !tail_oor) begin
            data_reg <= ram_dout;
        end
    end

    assign tail_word = tail_src ? data_reg : ram_dout;
`else
    assign hit       = 1'b0;
    assign tail_word = ram_dout;
`endif

    // Lane select and tail masking.
    logic [31:0]          lane_base;
    logic [DEC_WIDTH-1:0] lane_data;
    logic [DEC_WIDTH-1:0] rsp_data_d;

    always_comb begin
        lane_base  = 32'(tail_lane) * DEC_WIDTH;
        lane_data  = tail_word[lane_base +: DEC_WIDTH];
        rsp_data_d = '0;
        if (tail_valid && !tail_oor) begin
            rsp_data_d = tail_last ? (lane_data & LAST_MASK) : lane_data;
        end
    end

    // Response register; a tail entry caught by clear is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= tail_valid & ~clear;
            rsp_data  <= clear ? '0 : rsp_data_d;
        end
    end

endmodule
